demodulador_fsk: RTL

//  Downstream of the 1000/1500 Hz FSK sine modulator: consumes its 8-bit unsigned samples
//  (midscale 128) and recovers the data bit. Counts midscale crossings in a 32-sample bit

---
 rtl/demodulador_fsk.sv | 133 +++++++++++++
 1 files changed

// File: rtl/demodulador_fsk.sv
// demodulador_fsk: recovers FSK data bits by counting
// midscale crossings inside an aligned sample window.
module demodulador_fsk #(
  parameter int AMOSTRAS_POR_BIT = 32,
  parameter int LIMIAR_MEIO      = 128,
  parameter int LIMIAR_CRUZ      = 3,
  parameter int MAX_CRUZ         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] amostra,
  input  logic       amostra_valida,
  output logic       bit_dado,
  output logic       bit_valido,
  output logic       portadora,
  output logic       erro_janela
);

  localparam int JW = $clog2(AMOSTRAS_POR_BIT);
  localparam logic [JW-1:0] ULTIMA =
    JW'(AMOSTRAS_POR_BIT - 1);
  localparam logic [JW-1:0] UM_J = JW'(1);
  localparam logic [7:0] MEIO = 8'(LIMIAR_MEIO);
  localparam logic [5:0] CRUZ_MAX = 6'(MAX_CRUZ);
  localparam logic [5:0] CRUZ_UM = 6'(LIMIAR_CRUZ);

  typedef enum logic [1:0] {
    SEM_PORTADORA,
    ADQUIRINDO,
    RASTREANDO
  } estado_t;

  estado_t       estado, estado_d;
  logic [JW-1:0] janela, janela_d;
  logic [5:0]    cruz, cruz_d;
  logic          sinal_ant, sinal_ant_d;
  logic          bit_dado_d;
  logic          bit_valido_d;
  logic          portadora_d;
  logic          erro_d;

  logic          sinal;
  logic          cruzou;
  logic          fecha;
  logic          nula;
  logic          excesso;
  logic [5:0]    cruz_sat;

  assign sinal    = amostra >= MEIO;
  assign cruzou   = sinal ^ sinal_ant;
  assign cruz_sat = (&cruz) ? cruz
                  : cruz + {5'd0, cruzou};
  assign fecha    = janela == ULTIMA;
  assign nula     = cruz_sat == 6'd0;
  assign excesso  = cruz_sat > CRUZ_MAX;

  // State and output registers, all advanced only by the next-state logic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado      <= SEM_PORTADORA;
      janela      <= '0;
      cruz        <= '0;
      sinal_ant   <= 1'b0;
      bit_dado    <= 1'b0;
      bit_valido  <= 1'b0;
      portadora   <= 1'b0;
      erro_janela <= 1'b0;
    end else begin
      estado      <= estado_d;
      janela      <= janela_d;
      cruz        <= cruz_d;
      sinal_ant   <= sinal_ant_d;
      bit_dado    <= bit_dado_d;
      bit_valido  <= bit_valido_d;
      portadora   <= portadora_d;
      erro_janela <= erro_d;
    end
  end

  // Acquisition/tracking FSM and window close decision
  always_comb begin
    estado_d     = estado;
    janela_d     = janela;
    cruz_d       = cruz;
    sinal_ant_d  = sinal_ant;
    bit_dado_d   = bit_dado;
    portadora_d  = portadora;
    bit_valido_d = 1'b0;
    erro_d       = 1'b0;
    if (amostra_valida) begin
      sinal_ant_d = sinal;
      unique case (estado)
        SEM_PORTADORA: begin
          estado_d = ADQUIRINDO;
        end
        ADQUIRINDO: begin
          if (cruzou) begin
            janela_d    = UM_J;
            cruz_d      = 6'd1;
            portadora_d = 1'b1;
            estado_d    = RASTREANDO;
          end
        end
        RASTREANDO: begin
          if (fecha) begin
            janela_d = '0;
            cruz_d   = '0;
            unique case (1'b1)
              nula: begin
                portadora_d = 1'b0;
                estado_d    = SEM_PORTADORA;
              end
              excesso: begin
                erro_d = 1'b1;
              end
              default: begin
                bit_dado_d   = cruz_sat >= CRUZ_UM;
                bit_valido_d = 1'b1;
              end
            endcase
          end else begin
            janela_d = janela + UM_J;
            cruz_d   = cruz_sat;
          end
        end
        default: begin
          estado_d = SEM_PORTADORA;
        end
      endcase
    end
  end

endmodule
